dac_table_8x_hls_deadlock_reporter: RTL and testbench
=====================================================

# dac_table_8x_hls_deadlock_reporter

Downstream consumer of the `block` output of the dac_table_8x idx0 deadlock monitor. Qualifies `block` with a persistence filter, and on confirmation latches a sticky deadlock flag. Captures a diagnostic snapshot of the AXIS block and instance idle vectors plus a timestamp, and hands the snapshot out once over a valid/ready report port to the debug/status register bank.

## Interface
Parameters:
- `AXIS_W`, 3: width of the AXIS block-signal vector.
- `IDLE_W`, 2: width of the instance idle vector.
- `CONFIRM_CYCLES`, 1024: consecutive high samples of `block` required to declare deadlock. Must be ≥2.
- `TS_W`, 32: timestamp counter width.

Ports (reset `reset`: synchronous, active-high; clock `clock`):
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous active-high reset.
- `block`, in, 1: monitor deadlock indication.
- `axis_block_sigs`, in, AXIS_W: per-stream blocked flags, same vector the monitor sees.
- `inst_idle_sigs`, in, IDLE_W: per-instance idle flags.
- `clear`, in, 1: software clear of flag, counters and any pending report.
- `deadlock`, out, 1: sticky confirmed-deadlock flag.
- `report_valid`, out, 1: snapshot available.
- `report_ready`, in, 1: consumer accepts snapshot.
- `report_axis`, out, AXIS_W: OR of `axis_block_sigs` over the confirm window.
- `report_idle`, out, IDLE_W: `inst_idle_sigs` at the confirming sample.
- `report_ts`, out, TS_W: timestamp at the first high sample of `block`.
- `glitch_count`, out, 8: count of aborted confirm windows, saturating.

## Operation
- Free-running timestamp `ts` increments every cycle and wraps modulo 2^TS_W. It is cleared only by `reset`; `clear` does not affect it.
- The FSM has four states: IDLE, CONFIRM, REPORT, LATCHED. Each state is described below.
- IDLE:
  - On `block`=1: count←1, snapshot_ts←`ts`, acc_axis←`axis_block_sigs`, next state CONFIRM.
- CONFIRM:
  - On `block`=0: glitch_count←min(glitch_count+1, 255), count←0, next state IDLE.
  - On `block`=1 with count==CONFIRM_CYCLES-1: acc_axis |= `axis_block_sigs`, report_idle←`inst_idle_sigs`, `deadlock`←1, next state REPORT.
  - Otherwise: count++ and acc_axis |= `axis_block_sigs`.
- REPORT:
  - `report_valid`=1; all report fields are held stable.
  - On `report_valid`&`report_ready`: next state LATCHED.
  - `block` is ignored in this state.
- LATCHED:
  - `deadlock` stays 1. `block` is ignored and no new report is generated.
- `clear`:
  - Has priority over every transition, in every state.
  - Next state IDLE; `deadlock`, count, glitch_count, acc_axis, report_idle, report_ts are all set to 0.
  - A pending report is dropped: `report_valid` falls the next cycle with no handshake.
- `clear` and `block` asserted together: `clear` wins. `block` is re-evaluated from IDLE on the following cycle.
- Confirm count width is clog2(CONFIRM_CYCLES).

## Timing
- All outputs are registered and behave as Moore outputs of the state and the capture registers.
- Reset values: `deadlock`=0, `report_valid`=0, `report_axis`=0, `report_idle`=0, `report_ts`=0, `glitch_count`=0. State IDLE, `ts`=0.
- Let the first high sample of `block` be at edge k, with `block` held high. Then:
  - `deadlock` and `report_valid` become 1 after edge k+CONFIRM_CYCLES-1.
  - `report_ts` equals the `ts` value sampled at edge k.
- Handshake:
  - `report_valid` never drops without either a handshake or a `clear`.
  - If `report_ready` is already high when `report_valid` rises, the transfer completes at the next edge, so `report_valid` lasts exactly 1 cycle.
- Any single low sample of `block` inside CONFIRM restarts the window. A new window can start on the edge after the return to IDLE.
- `reset` mid-operation: all state returns to reset values on the next edge, and any pending report is discarded silently.

## Structure
- Shared package `dac_table_8x_dbg_pkg`:
  - FSM state enum (IDLE/CONFIRM/REPORT/LATCHED).
  - Report struct {axis, idle, ts}.
  - `GLITCH_MAX`=255.
- One natural sub-module, `dac_table_8x_dbg_persist_filter`: the confirm counter plus the glitch counter, with outputs `confirmed` and `aborted`.
- The top level holds the FSM, the capture registers and the timestamp.

## Test plan
All scenarios use CONFIRM_CYCLES=8.
- **Held block:** `block` high from edge 10 with `axis_block_sigs` 3'b001, then 3'b100 from edge 13 → `report_valid`=`deadlock`=1 after edge 17; `report_axis`=3'b101; `report_ts`=10.
- **Glitch:** `block` high for 7 edges then low 1 edge, repeated 300 times → `deadlock` stays 0; `glitch_count` saturates at 255.
- **Backpressure:** `report_ready` held low for 20 cycles after `report_valid` → fields stable and `report_valid` held. On `report_ready`=1 the handshake occurs, state goes LATCHED, `report_valid`=0, `deadlock`=1.
- **Clear while pending:** `clear` asserted while `report_valid`=1, with `report_ready`=0 → next cycle all outputs are 0 and state is IDLE. `block` still high then gives a new report 8 edges later with a new `report_ts`.
- **Clear vs block:** `clear` and `block` both high at edge 5 → state stays IDLE; confirmation counts from edge 6, so `report_valid` rises after edge 13.
- **Reset and wrap:** `reset` asserted during CONFIRM → all outputs 0. Separately, with TS_W=4, `ts` wraps 15→0 and `report_ts` captures the wrapped value.

Source files
------------

// File: rtl/dac_table_8x_dbg_pkg.sv
// Shared types and constants for the dac_table_8x deadlock debug/report logic.
package dac_table_8x_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_REPORT  = 2'd2,
    ST_LATCHED = 2'd3
  } dbg_state_t;

  localparam int GLITCH_MAX = 255;

  // Register-bank view of one snapshot at the default widths (3/2/32).
  typedef struct packed {
    logic [2:0]  axis;
    logic [1:0]  idle;
    logic [31:0] ts;
  } dbg_report_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'(GLITCH_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dac_table_8x_dbg_persist_filter.sv
// Persistence filter: counts consecutive high samples of block while the
// reporter is confirming, and counts windows that were aborted by a low sample.
module dac_table_8x_dbg_persist_filter
  import dac_table_8x_dbg_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       block,
  input  logic       start,
  input  logic       active,
  output logic       confirmed,
  output logic       aborted,
  output logic [7:0] glitch_count
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONFIRM_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_glitch;

  // The first high sample is taken in IDLE (start), so the window ends at LAST.
  assign confirmed    = active & block & (r_count == LAST);
  assign aborted      = active & ~block;
  assign glitch_count = r_glitch;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count  <= '0;
      r_glitch <= '0;
    end else if (start) begin
      r_count <= CNT_W'(1);
    end else if (aborted) begin
      r_count  <= '0;
      r_glitch <= sat_inc8(r_glitch);
    end else if (confirmed) begin
      r_count <= '0;
    end else if (active) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_table_8x_hls_deadlock_reporter.sv
// Qualifies the monitor's block indication, latches a sticky deadlock flag and
// hands a one-shot diagnostic snapshot to the debug register bank.
module dac_table_8x_hls_deadlock_reporter
  import dac_table_8x_dbg_pkg::*;
#(
  parameter int AXIS_W         = 3,
  parameter int IDLE_W         = 2,
  parameter int CONFIRM_CYCLES = 1024,
  parameter int TS_W           = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [AXIS_W-1:0] axis_block_sigs,
  input  logic [IDLE_W-1:0] inst_idle_sigs,
  input  logic              clear,
  output logic              deadlock,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [AXIS_W-1:0] report_axis,
  output logic [IDLE_W-1:0] report_idle,
  output logic [TS_W-1:0]   report_ts,
  output logic [7:0]        glitch_count
);

  dbg_state_t        r_state;
  dbg_state_t        w_state_next;
  logic [TS_W-1:0]   r_ts;
  logic [TS_W-1:0]   r_snap_ts;
  logic [AXIS_W-1:0] r_acc_axis;
  logic [IDLE_W-1:0] r_rep_idle;
  logic              r_deadlock;
  logic              w_start;
  logic              w_active;
  logic              w_confirmed;
  logic              w_aborted;

  assign w_start  = (r_state == ST_IDLE) & block;
  assign w_active = (r_state == ST_CONFIRM);

  dac_table_8x_dbg_persist_filter #(
    .CONFIRM_CYCLES(CONFIRM_CYCLES)
  ) u_filter (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .block       (block),
    .start       (w_start),
    .active      (w_active),
    .confirmed   (w_confirmed),
    .aborted     (w_aborted),
    .glitch_count(glitch_count)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (block) w_state_next = ST_CONFIRM;
      ST_CONFIRM: begin
        if (w_aborted)        w_state_next = ST_IDLE;
        else if (w_confirmed) w_state_next = ST_REPORT;
      end
      ST_REPORT:  if (report_ready) w_state_next = ST_LATCHED;
      ST_LATCHED: w_state_next = ST_LATCHED;
      default:    w_state_next = ST_IDLE;
    endcase
    // Software clear overrides every transition, including a new window start.
    if (clear) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_snap_ts  <= '0;
      r_acc_axis <= '0;
      r_rep_idle <= '0;
      r_deadlock <= 1'b0;
    end else begin
      if (w_start) begin
        r_snap_ts  <= r_ts;
        r_acc_axis <= axis_block_sigs;
      end else if (w_active && block) begin
        r_acc_axis <= r_acc_axis | axis_block_sigs;
      end
      if (w_confirmed) begin
        r_rep_idle <= inst_idle_sigs;
        r_deadlock <= 1'b1;
      end
    end
  end

  assign deadlock     = r_deadlock;
  assign report_valid = (r_state == ST_REPORT);
  assign report_axis  = r_acc_axis;
  assign report_idle  = r_rep_idle;
  assign report_ts    = r_snap_ts;

endmodule

// File: tb/tb_dac_table_8x_hls_deadlock_reporter.sv
// Randomized scoreboard bench for the deadlock reporter (CONFIRM_CYCLES=8, TS_W=4).
module tb_dac_table_8x_hls_deadlock_reporter;

  localparam int CONF = 8;

  logic       clock;
  logic       reset;
  logic       block;
  logic [2:0] axis_block_sigs;
  logic [1:0] inst_idle_sigs;
  logic       clear;
  logic       deadlock;
  logic       report_valid;
  logic       report_ready;
  logic [2:0] report_axis;
  logic [1:0] report_idle;
  logic [3:0] report_ts;
  logic [7:0] glitch_count;

  dac_table_8x_hls_deadlock_reporter #(
    .AXIS_W(3), .IDLE_W(2), .CONFIRM_CYCLES(CONF), .TS_W(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .block          (block),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs (inst_idle_sigs),
    .clear          (clear),
    .deadlock       (deadlock),
    .report_valid   (report_valid),
    .report_ready   (report_ready),
    .report_axis    (report_axis),
    .report_idle    (report_idle),
    .report_ts      (report_ts),
    .glitch_count   (glitch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] axis;
    logic [1:0] idle;
    logic [3:0] ts;
  } rep_t;

  rep_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: state the DUT should hold after the next active edge.
  int         m_ts      = 0;
  int         m_streak  = 0;
  int         m_glitch  = 0;
  bit         m_pending = 0;
  bit         m_latched = 0;
  bit         m_dl      = 0;
  bit         m_zero    = 1;
  logic [2:0] m_or      = '0;
  logic [3:0] m_start_ts = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit blk, input bit rdy,
                      input logic [2:0] ax, input logic [1:0] id);
    int   ts_now;
    rep_t r;
    @(negedge clock);
    reset = rst; clear = clr; block = blk; report_ready = rdy;
    axis_block_sigs = ax; inst_idle_sigs = id;
    if (rst) begin
      m_ts = 0; m_streak = 0; m_glitch = 0; m_pending = 0;
      m_latched = 0; m_dl = 0; m_zero = 1;
    end else begin
      ts_now = m_ts;
      m_ts = (m_ts + 1) % 16;
      if (clr) begin
        m_streak = 0; m_glitch = 0; m_pending = 0; m_latched = 0; m_dl = 0; m_zero = 1;
      end else if (m_pending) begin
        if (rdy) begin
          m_pending = 0;
          m_latched = 1;
        end
      end else if (m_latched) begin
        m_latched = 1;
      end else if (m_streak == 0) begin
        if (blk) begin
          m_streak = 1; m_start_ts = 4'(ts_now); m_or = ax; m_zero = 0;
        end
      end else if (!blk) begin
        m_streak = 0;
        if (m_glitch < 255) m_glitch++;
      end else begin
        m_or = m_or | ax;
        m_streak++;
        if (m_streak == CONF) begin
          m_streak = 0; m_pending = 1; m_dl = 1;
          r.axis = m_or; r.idle = id; r.ts = m_start_ts;
          exp_q.push_back(r);
        end
      end
    end
  endtask

  function automatic logic [2:0] rax();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [1:0] rid();
    return 2'($urandom_range(0, 3));
  endfunction

  // Monitor: compares DUT outputs one step after each active edge.
  initial begin
    rep_t cur;
    bit   prev_valid;
    prev_valid = 0;
    cur.axis = '0; cur.idle = '0; cur.ts = '0;
    forever begin
      @(posedge clock);
      #1;
      chk("deadlock", 32'(deadlock), 32'(m_dl));
      chk("report_valid", 32'(report_valid), 32'(m_pending));
      chk("glitch_count", 32'(glitch_count), 32'(m_glitch));
      if (report_valid && !prev_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL report_unexpected: got report_valid=1 expected no report at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
          $display("report ts=%0d axis=%b idle=%b at %0t", cur.ts, cur.axis, cur.idle, $time);
        end
      end
      if (report_valid) begin
        chk("report_axis", 32'(report_axis), 32'(cur.axis));
        chk("report_idle", 32'(report_idle), 32'(cur.idle));
        chk("report_ts", 32'(report_ts), 32'(cur.ts));
      end
      if (m_zero) begin
        chk("cleared_axis", 32'(report_axis), 32'd0);
        chk("cleared_idle", 32'(report_idle), 32'd0);
        chk("cleared_ts", 32'(report_ts), 32'd0);
      end
      prev_valid = report_valid;
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; block = 1'b0; report_ready = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0;
    repeat (3) step(1, 0, 0, 0, 3'd0, 2'd0);

    // Held block with a changing stream vector, then 20 cycles of backpressure.
    repeat (4) step(0, 0, 0, 0, rax(), rid());
    for (int i = 0; i < CONF; i++) step(0, 0, 1, 0, (i < 3) ? 3'b001 : 3'b100, rid());
    repeat (20) step(0, 0, 1'($urandom_range(0, 1)), 0, rax(), rid());
    step(0, 0, 1, 1, rax(), rid());
    repeat (5) step(0, 0, 1, 1, rax(), rid());

    // Clear while a report is pending, block kept high.
    step(0, 1, 1, 0, rax(), rid());
    repeat (CONF + 3) step(0, 0, 1, 0, rax(), rid());
    step(0, 1, 1, 0, rax(), rid());
    repeat (CONF + 3) step(0, 0, 1, 1, rax(), rid());

    // Clear and block together, then a full window with ready already high.
    step(0, 1, 0, 0, rax(), rid());
    step(0, 1, 1, 0, rax(), rid());
    repeat (CONF + 2) step(0, 0, 1, 1, rax(), rid());

    // Repeated glitches saturate the glitch counter.
    step(0, 1, 0, 0, rax(), rid());
    repeat (300) begin
      repeat (CONF - 1) step(0, 0, 1, 0, rax(), rid());
      step(0, 0, 0, 0, rax(), rid());
    end

    // Reset in the middle of a confirm window.
    repeat (4) step(0, 0, 1, 0, rax(), rid());
    step(1, 0, 1, 0, rax(), rid());
    repeat (CONF + 4) step(0, 0, 1, 1, rax(), rid());

    // Random traffic with occasional clear/reset.
    repeat (3000) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0), rax(), rid());
    end
    repeat (4) step(0, 0, 0, 1, rax(), rid());

    @(posedge clock);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
